// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers EX..WB; produces data/control stall, ID flush and EX forwarding selects.
// Latency: stall/flush_id are combinational in the same cycle; ex_fwd_a/b are registered on the ID->EX move (valid while the consumer is in EX).
// Backpressure: stall holds PC and IF/ID and injects a bubble into slot 1; an honoured redirect squashes slots younger than the branch.
module hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 2,
    parameter int CTRL_MODE  = 0,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [ADDR_W-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              id_is_ctrl,
    input  logic              redirect,
    output logic              stall,
    output logic              flush_id,
    output logic [SEL_W-1:0]  ex_fwd_a,
    output logic [SEL_W-1:0]  ex_fwd_b,
    output logic [DEPTH-1:0]  slot_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic              load;
        logic              ctrl;
    } slot_t;

    // Array index k holds slot k+1 (index 0 = EX, index DEPTH-1 = WB).
    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [SEL_W-1:0] ex_fwd_a_q, ex_fwd_a_d;
    logic [SEL_W-1:0] ex_fwd_b_q, ex_fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             lu_a, lu_b;
    logic             ctrl_haz;
    logic             redir_hon;
    logic             issue;

    // Youngest matching writer per source: scan oldest to youngest so the youngest overwrites.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        lu_a  = 1'b0;
        lu_b  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_q[k].valid && slot_q[k].wr && id_rs_used && (slot_q[k].addr == id_rs)) begin
                sel_a = (k < DEPTH - 1) ? SEL_W'(k + 1) : '0;
                lu_a  = slot_q[k].load && (k + 1 < LOAD_STAGE);
            end
            if (slot_q[k].valid && slot_q[k].wr && id_rt_used && (slot_q[k].addr == id_rt)) begin
                sel_b = (k < DEPTH - 1) ? SEL_W'(k + 1) : '0;
                lu_b  = slot_q[k].load && (k + 1 < LOAD_STAGE);
            end
        end
    end

    // Control hazard, redirect qualification and the resulting stall/flush decisions.
    always_comb begin
        ctrl_haz = 1'b0;
        if (CTRL_MODE == 0) begin
            for (int k = 0; k < BR_STAGE - 1; k++) begin
                if (slot_q[k].valid && slot_q[k].ctrl) begin
                    ctrl_haz = 1'b1;
                end
            end
        end
        redir_hon = redirect && slot_q[BR_STAGE-1].valid && slot_q[BR_STAGE-1].ctrl;
        stall     = (lu_a || lu_b || ctrl_haz) && id_valid && !redir_hon;
        flush_id  = redir_hon;
        issue     = id_valid && !stall && !redir_hon;
    end

    // Next scoreboard contents: shift one slot, squash branch-younger slots on redirect, load slot 1.
    always_comb begin
        slot_d[0] = '0;
        if (issue) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].wr    = id_wr_en && (id_wr_addr != '0);
            slot_d[0].addr  = id_wr_addr;
            slot_d[0].load  = id_is_load;
            slot_d[0].ctrl  = id_is_ctrl;
        end
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
            if (redir_hon && (k - 1 < BR_STAGE - 1)) begin
                slot_d[k] = '0;
            end
        end
        ex_fwd_a_d = issue ? sel_a : '0;
        ex_fwd_b_d = issue ? sel_b : '0;
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_id && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            ex_fwd_a_q  <= '0;
            ex_fwd_b_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            ex_fwd_a_q  <= ex_fwd_a_d;
            ex_fwd_b_q  <= ex_fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Output views of the registered state.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_valid[k] = slot_q[k].valid;
        end
        ex_fwd_a  = ex_fwd_a_q;
        ex_fwd_b  = ex_fwd_b_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instance 0 = defaults (hold-until-resolved), instance 1 = predict-not-taken with 2-bit counters.
// A history model (instructions tagged by the cycle they entered EX) is checked against both instances every cycle.
// Directed sequences add literal expectations for the scenarios of interest.
module tb_hazard_scoreboard;

    localparam int D  = 3;
    localparam int LS = 2;
    localparam int BS = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic       id_valid   [2];
    logic [4:0] id_rs      [2];
    logic [4:0] id_rt      [2];
    logic       id_rs_used [2];
    logic       id_rt_used [2];
    logic       id_wr_en   [2];
    logic [4:0] id_wr_addr [2];
    logic       id_is_load [2];
    logic       id_is_ctrl [2];
    logic       redirect   [2];

    logic       stall_o [2];
    logic       flush_o [2];
    logic [1:0] fa_o    [2];
    logic [1:0] fb_o    [2];
    logic [2:0] sv_o    [2];
    logic [15:0] scnt0, fcnt0;
    logic [1:0]  scnt1, fcnt1;

    hazard_scoreboard dut0 (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
        .id_rs_used(id_rs_used[0]), .id_rt_used(id_rt_used[0]),
        .id_wr_en(id_wr_en[0]), .id_wr_addr(id_wr_addr[0]),
        .id_is_load(id_is_load[0]), .id_is_ctrl(id_is_ctrl[0]),
        .redirect(redirect[0]),
        .stall(stall_o[0]), .flush_id(flush_o[0]),
        .ex_fwd_a(fa_o[0]), .ex_fwd_b(fb_o[0]), .slot_valid(sv_o[0]),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    hazard_scoreboard #(.CTRL_MODE(1), .CNT_W(2)) dut1 (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
        .id_rs_used(id_rs_used[1]), .id_rt_used(id_rt_used[1]),
        .id_wr_en(id_wr_en[1]), .id_wr_addr(id_wr_addr[1]),
        .id_is_load(id_is_load[1]), .id_is_ctrl(id_is_ctrl[1]),
        .redirect(redirect[1]),
        .stall(stall_o[1]), .flush_id(flush_o[1]),
        .ex_fwd_a(fa_o[1]), .ex_fwd_b(fb_o[1]), .slot_valid(sv_o[1]),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- history model ----------------
    // Entry e = c & 7 describes the instruction that occupied EX during cycle c.
    // During cycle cyc an entry from cycle c sits in pipeline position cyc - c + 1.
    int         cyc = 0;
    bit         m_iss  [2][8];
    bit         m_kill [2][8];
    bit         m_wr   [2][8];
    logic [4:0] m_addr [2][8];
    bit         m_load [2][8];
    bit         m_ctrl [2][8];
    int         m_sa   [2][8];
    int         m_sb   [2][8];
    int         m_scnt [2];
    int         m_fcnt [2];

    function automatic int ent(input int pos);
        return (cyc - pos + 1) & 7;
    endfunction

    function automatic bit live(input int i, input int pos);
        if (cyc - pos + 1 < 0) return 1'b0;
        return m_iss[i][ent(pos)] && !m_kill[i][ent(pos)];
    endfunction

    task automatic lookup(input int i, input logic [4:0] s, input logic used,
                          output int sel, output bit lu);
        bit found;
        found = 1'b0;
        sel   = 0;
        lu    = 1'b0;
        for (int pos = 1; pos <= D; pos++) begin
            if (!found && used && live(i, pos) && m_wr[i][ent(pos)] && (m_addr[i][ent(pos)] == s)) begin
                found = 1'b1;
                sel   = (pos <= D - 1) ? pos : 0;
                lu    = m_load[i][ent(pos)] && (pos < LS);
            end
        end
    endtask

    // Compare process: every negedge, check both instances against the model, then advance the model.
    always @(negedge CLK) begin
        int         sa, sb, efa, efb, cmax, e;
        bit         la, lb, ch, fl, st, iss;
        logic [2:0] esv;
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 8; k++) begin
                    m_iss[i][k]  = 1'b0;
                    m_kill[i][k] = 1'b0;
                end
                m_scnt[i] = 0;
                m_fcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                lookup(i, id_rs[i], id_rs_used[i], sa, la);
                lookup(i, id_rt[i], id_rt_used[i], sb, lb);
                ch = 1'b0;
                if (i == 0) begin
                    for (int pos = 1; pos < BS; pos++) begin
                        if (live(i, pos) && m_ctrl[i][ent(pos)]) ch = 1'b1;
                    end
                end
                fl   = redirect[i] && live(i, BS) && m_ctrl[i][ent(BS)];
                st   = (la || lb || ch) && id_valid[i] && !fl;
                iss  = id_valid[i] && !st && !fl;
                for (int pos = 1; pos <= D; pos++) esv[pos-1] = live(i, pos);
                efa  = m_iss[i][ent(1)] ? m_sa[i][ent(1)] : 0;
                efb  = m_iss[i][ent(1)] ? m_sb[i][ent(1)] : 0;
                cmax = (i == 0) ? 65535 : 3;

                check($sformatf("i%0d_c%0d_stall", i, cyc), 32'(stall_o[i]), 32'(st));
                check($sformatf("i%0d_c%0d_flush", i, cyc), 32'(flush_o[i]), 32'(fl));
                check($sformatf("i%0d_c%0d_slot_valid", i, cyc), 32'(sv_o[i]), 32'(esv));
                check($sformatf("i%0d_c%0d_fwd_a", i, cyc), 32'(fa_o[i]), 32'(efa));
                check($sformatf("i%0d_c%0d_fwd_b", i, cyc), 32'(fb_o[i]), 32'(efb));
                check($sformatf("i%0d_c%0d_stall_cnt", i, cyc),
                      (i == 0) ? 32'(scnt0) : 32'(scnt1), 32'(m_scnt[i]));
                check($sformatf("i%0d_c%0d_flush_cnt", i, cyc),
                      (i == 0) ? 32'(fcnt0) : 32'(fcnt1), 32'(m_fcnt[i]));

                if (fl) begin
                    for (int pos = 1; pos < BS; pos++) begin
                        if (live(i, pos)) m_kill[i][ent(pos)] = 1'b1;
                    end
                end
                e = (cyc + 1) & 7;
                m_iss[i][e]  = iss;
                m_kill[i][e] = 1'b0;
                m_wr[i][e]   = iss && id_wr_en[i] && (id_wr_addr[i] != 5'd0);
                m_addr[i][e] = id_wr_addr[i];
                m_load[i][e] = iss && id_is_load[i];
                m_ctrl[i][e] = iss && id_is_ctrl[i];
                m_sa[i][e]   = iss ? sa : 0;
                m_sb[i][e]   = iss ? sb : 0;
                if (st && m_scnt[i] < cmax) m_scnt[i]++;
                if (fl && m_fcnt[i] < cmax) m_fcnt[i]++;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input int i, input bit v, input int rs, input bit rsu,
                          input int rt, input bit rtu, input bit we, input int wa,
                          input bit ld, input bit ct);
        id_valid[i]   = v;
        id_rs[i]      = 5'(rs);
        id_rs_used[i] = rsu;
        id_rt[i]      = 5'(rt);
        id_rt_used[i] = rtu;
        id_wr_en[i]   = we;
        id_wr_addr[i] = 5'(wa);
        id_is_load[i] = ld;
        id_is_ctrl[i] = ct;
    endtask

    task automatic idle(input int i);
        set_id(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        redirect[i] = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        idle(0);
        idle(1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("reset_slot_valid", 32'(sv_o[0]), 32'd0);
        check("reset_fwd_a", 32'(fa_o[0]), 32'd0);
        check("reset_stall_cnt", 32'(scnt0), 32'd0);

        // ALU forwarding distances on instance 0
        set_id(0, 1, 0, 0, 0, 0, 1, 3, 0, 0); tick();            // add $3
        set_id(0, 1, 3, 1, 0, 0, 1, 6, 0, 0);                    // sub rs=$3
        #1 check("alu_no_stall", 32'(stall_o[0]), 32'd0);
        tick();
        check("fwd_adjacent", 32'(fa_o[0]), 32'd1);
        set_id(0, 1, 0, 0, 0, 0, 1, 4, 0, 0); tick();            // add $4
        set_id(0, 1, 0, 0, 0, 0, 1, 9, 0, 0); tick();            // unrelated $9
        set_id(0, 1, 4, 1, 0, 0, 0, 0, 0, 0); tick();            // rs=$4, one gap
        check("fwd_gap1", 32'(fa_o[0]), 32'd2);
        set_id(0, 1, 4, 1, 0, 0, 0, 0, 0, 0); tick();            // rs=$4, two gap (writer in WB)
        check("fwd_gap2", 32'(fa_o[0]), 32'd0);
        set_id(0, 1, 0, 0, 0, 0, 1, 0, 0, 0); tick();            // writes $0
        set_id(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); tick();            // reads $0
        check("fwd_r0", 32'(fa_o[0]), 32'd0);

        // Youngest writer wins on operand b
        set_id(0, 1, 0, 0, 0, 0, 1, 7, 0, 0); tick();
        set_id(0, 1, 0, 0, 0, 0, 1, 7, 0, 0); tick();
        set_id(0, 1, 0, 0, 7, 1, 0, 0, 0, 0); tick();
        check("youngest_fwd_b", 32'(fb_o[0]), 32'd1);
        idle(0); tick();

        // Load-use: one stall cycle, bubble, then forward from slot 2
        set_id(0, 1, 0, 0, 0, 0, 1, 5, 1, 0); tick();            // lw $5
        set_id(0, 1, 5, 1, 0, 0, 1, 2, 0, 0);                    // add rs=$5
        #1 check("loaduse_stall", 32'(stall_o[0]), 32'd1);
        tick();
        check("loaduse_bubble", 32'(sv_o[0][0]), 32'd0);
        check("loaduse_stall_end", 32'(stall_o[0]), 32'd0);
        tick();
        check("loaduse_fwd", 32'(fa_o[0]), 32'd2);
        check("loaduse_cnt", 32'(scnt0), 32'd1);

        // Hold-until-resolved control: stall, then honoured redirect, then ignored redirect
        set_id(0, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick();            // beq
        set_id(0, 1, 0, 0, 0, 0, 1, 8, 0, 0);                    // add $8
        #1 check("ctrl_stall", 32'(stall_o[0]), 32'd1);
        tick();
        redirect[0] = 1'b1;
        #1 check("redirect_flush", 32'(flush_o[0]), 32'd1);
        check("redirect_no_stall", 32'(stall_o[0]), 32'd0);
        tick();
        check("flush_cnt_one", 32'(fcnt0), 32'd1);
        check("stall_cnt_two", 32'(scnt0), 32'd2);
        #1 check("redirect_ignored", 32'(flush_o[0]), 32'd0);
        tick();
        redirect[0] = 1'b0;

        // Fill the pipe, then assert reset mid-cycle
        set_id(0, 1, 0, 0, 0, 0, 1, 10, 0, 0); tick();
        set_id(0, 1, 10, 1, 0, 0, 1, 11, 0, 0); tick();
        set_id(0, 1, 11, 1, 0, 0, 1, 12, 0, 0);
        #1 check("prerst_slot_valid", 32'(sv_o[0]), 32'd7);
        check("prerst_fwd_a", 32'(fa_o[0]), 32'd1);
        RST = 1'b1;
        #1 check("midrst_slot_valid", 32'(sv_o[0]), 32'd0);
        check("midrst_fwd_a", 32'(fa_o[0]), 32'd0);
        check("midrst_stall_cnt", 32'(scnt0), 32'd0);
        check("midrst_flush_cnt", 32'(fcnt0), 32'd0);
        check("midrst_stall", 32'(stall_o[0]), 32'd0);
        check("midrst_flush", 32'(flush_o[0]), 32'd0);
        tick();
        RST = 1'b0;
        set_id(0, 1, 0, 0, 0, 0, 1, 13, 0, 0); tick();
        check("postrst_shift", 32'(sv_o[0]), 32'd1);
        idle(0);

        // Predict-not-taken on instance 1
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick();            // beq
        set_id(1, 1, 0, 0, 0, 0, 1, 14, 1, 0);                   // lw $14
        #1 check("m1_no_ctrl_stall", 32'(stall_o[1]), 32'd0);
        tick();
        set_id(1, 1, 14, 1, 0, 0, 1, 15, 0, 0);                  // load-use consumer
        redirect[1] = 1'b1;
        #1 check("m1_flush_wins_stall", 32'(stall_o[1]), 32'd0);
        check("m1_flush", 32'(flush_o[1]), 32'd1);
        tick();
        idle(1);
        check("m1_squash_slot_valid", 32'(sv_o[1]), 32'd4);
        check("m1_flush_cnt", 32'(fcnt1), 32'd1);
        check("m1_stall_cnt", 32'(scnt1), 32'd0);
        for (int n = 0; n < 4; n++) begin
            set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
            idle(1); tick();
            redirect[1] = 1'b1; tick();
            redirect[1] = 1'b0;
        end
        check("m1_flush_cnt_sat", 32'(fcnt1), 32'd3);
        idle(1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-control unit for the pipelined MIPS core. It replaces the fixed stall detector and fixed forwarding mux-select logic. It tracks every in-flight destination register from EX to WB in a DEPTH-slot scoreboard and produces, each cycle:
- the data-hazard stall,
- the registered EX operand forwarding selects,
- the flush for control transfers.

Control transfers are handled in one of two modes: stall-until-resolved or predict-not-taken. Saturating performance counters record stall and flush activity.

## Interface
Parameters:
- ADDR_W, 5, register address width.
- DEPTH, 3, number of post-decode stages tracked (slot 1 = EX, slot DEPTH = WB); legal ≥ 3.
- LOAD_STAGE, 2, slot at whose end load data becomes available; legal 1..DEPTH-1.
- BR_STAGE, 2, slot in which branch/jump redirect is resolved; legal 1..DEPTH-1.
- CTRL_MODE, 0, 0 = hold ID behind an unresolved control instruction; 1 = predict not-taken, flush on redirect.
- CNT_W, 16, performance counter width.
- SEL_W, $clog2(DEPTH), forwarding select width.

Ports (clock: one clock; reset: asynchronous, active-high):
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  ADDR_W  source register addresses.
- id_rs_used, id_rt_used  in  1  source is actually read.
- id_wr_en  in  1  instruction writes a register.
- id_wr_addr  in  ADDR_W  destination register.
- id_is_load  in  1  instruction is a load.
- id_is_ctrl  in  1  instruction is a branch or jump.
- redirect  in  1  taken branch/jump resolved in slot BR_STAGE.
- stall  out  1  hold PC and the IF/ID register; insert bubble into slot 1 (combinational).
- flush_id  out  1  squash IF/ID contents (combinational).
- ex_fwd_a, ex_fwd_b  out  SEL_W  operand source for the instruction in EX (registered).
- slot_valid  out  DEPTH  debug view of valid bits; bit k-1 = slot k.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Slot k fields: valid, wr, addr, load, ctrl.
- Entering slot 1 from ID: the instruction with wr = id_wr_en & (id_wr_addr != 0).
  - $0 is never recorded as written and never matched.
- Match: slot k matches source s when valid & wr & addr == s & s_used.
  - The youngest slot (smallest k) wins.
  - Slot DEPTH (WB) never forwards. The register file is write-before-read.
- Forwarding select, computed in ID, registered on the ID→EX move:
  - 0 = register file.
  - n = result from slot n+1, where n = (matching slot k at ID time) and k ≤ DEPTH-1.
  - If the youngest match is in slot DEPTH, the select is 0.
- Load-use hazard: youngest match is a load in slot k < LOAD_STAGE. Default: load in slot 1 gives a 1-cycle stall.
- Control hazard:
  - CTRL_MODE 0: stall while any valid ctrl is in slots 1..BR_STAGE-1.
  - CTRL_MODE 1: no control stall.
- redirect is honoured only when slot BR_STAGE is valid and ctrl; otherwise it is ignored.
- On an honoured redirect:
  - flush_id = 1.
  - Slots 1..BR_STAGE-1 are invalidated at the edge.
  - A bubble enters slot 1.
- Outputs:
  - stall = (data hazard | control hazard) & id_valid & ~redirect_honoured.
  - flush_id = redirect_honoured.
- Shift per edge: slot k+1 ← slot k. Slot 1 ← ID instruction, or a bubble if stall, flush, or ~id_valid. Bubbles have all fields 0 and fwd selects 0.
- Counters: +1 per cycle with stall = 1 (stall_cnt) or flush_id = 1 (flush_cnt). Each holds at all-ones.

## Timing
- RST asserted (async, including mid-operation): immediately all slots invalid, ex_fwd_a/b = 0, counters = 0; stall and flush_id read 0.
- First edge after RST release performs a normal shift.
- stall and flush_id are same-cycle combinational from ID inputs and scoreboard state.
- ex_fwd_* are valid for the whole cycle in which the consumer sits in EX.
- Load-use stall lasts exactly LOAD_STAGE - k cycles. The consumer then issues with its select pointing at the load's slot.
- Redirect and load-use in the same cycle: flush wins, stall = 0, stall_cnt is not incremented.
- Counter at saturation with an event: the counter holds and does not wrap.

## Test plan
Defaults unless noted (DEPTH=3, LOAD_STAGE=2, BR_STAGE=2, CTRL_MODE=0).
- Reset: fill all slots, assert RST mid-cycle -> slot_valid=3'b000, ex_fwd_a=0, both counters 0 before the next edge.
- ALU forwarding: add $3; sub rs=$3 next cycle -> ex_fwd_a=1 with sub in EX. One instruction gap -> 2. Two instruction gap -> 0. rs=$0 with a prior writer of $0 -> 0.
- Youngest wins: writers of $7 in slots 1 and 2, consumer in ID -> ex_fwd_b=1 on the next cycle.
- Load-use: lw $5; add rs=$5 -> stall=1 for exactly one cycle, slot 1 bubble, then ex_fwd_a=2, stall_cnt=1.
- CTRL_MODE 0: beq in slot 1 -> stall=1 for one cycle. Next cycle, redirect=1 -> flush_id=1, stall=0, flush_cnt=1. Redirect while slot 2 is not ctrl -> ignored.
- CTRL_MODE 1: beq followed by two instructions, redirect when beq is in slot 2 -> no stall, flush_id=1, slot 1 invalidated at the edge. Simultaneous load-use in ID -> stall=0. With CNT_W=2, four flushes -> flush_cnt=3.
